// File: rtl/id_ex_if.sv
// Bundle of signals between the ID stage, the ID/EX pipeline register and EX.
// master = ID/EX control side; slave = the ID/EX register itself.
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic [6:0]      id_opcode, ex_opcode;
  logic [2:0]      id_funct3, ex_funct3;
  logic [6:0]      id_funct7, ex_funct7;
  logic            id_Branch, id_MemREAD, id_MemtoReg, id_ALUSrc, id_RegWrite;
  logic [1:0]      id_MemWrite, ex_MemWrite;
  logic            ex_Branch, ex_MemREAD, ex_MemtoReg, ex_ALUSrc, ex_RegWrite;
  logic            id_valid, ex_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
  logic            ex_stall, flush, id_stall;

  modport master (
    output id_opcode, id_funct3, id_funct7, id_Branch, id_MemREAD, id_MemtoReg,
           id_ALUSrc, id_RegWrite, id_MemWrite, id_valid, id_pc, id_rs1_data,
           id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, ex_stall, flush,
    input  id_stall, ex_valid, ex_opcode, ex_funct3, ex_funct7, ex_Branch,
           ex_MemREAD, ex_MemtoReg, ex_ALUSrc, ex_RegWrite, ex_MemWrite, ex_pc,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd
  );

  modport slave (
    input  id_opcode, id_funct3, id_funct7, id_Branch, id_MemREAD, id_MemtoReg,
           id_ALUSrc, id_RegWrite, id_MemWrite, id_valid, id_pc, id_rs1_data,
           id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, ex_stall, flush,
    output id_stall, ex_valid, ex_opcode, ex_funct3, ex_funct7, ex_Branch,
           ex_MemREAD, ex_MemtoReg, ex_ALUSrc, ex_RegWrite, ex_MemWrite, ex_pc,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, bubble insertion, EX hold and flush.
// Optional macro ID_EX_PERF_CNT_EN adds saturating bubble/flush/hold counters.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_if.slave      bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_hold_cnt
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [1:0] WRITE_IDLE = 2'b00;

  logic uses_rs1, uses_rs2, load_use;

  assign uses_rs1 = !((bus.id_opcode == OP_LUI) || (bus.id_opcode == OP_AUIPC) ||
                      (bus.id_opcode == OP_JAL));
  assign uses_rs2 = (bus.id_opcode == OP_BRANCH) || (bus.id_opcode == OP_STORE) ||
                    (bus.id_opcode == OP_OP);

  assign load_use = bus.ex_valid && bus.ex_MemREAD && (bus.ex_rd != '0) && bus.id_valid &&
                    ((uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // Flush overrides any stall so IF/ID can take the redirect target.
  assign bus.id_stall = !bus.flush && (bus.ex_stall || load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_Branch   <= 1'b0;
      bus.ex_MemREAD  <= 1'b0;
      bus.ex_MemtoReg <= 1'b0;
      bus.ex_ALUSrc   <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_MemWrite <= WRITE_IDLE;
      bus.ex_opcode   <= '0;
      bus.ex_funct3   <= '0;
      bus.ex_funct7   <= '0;
      bus.ex_pc       <= '0;
      bus.ex_rs1_data <= '0;
      bus.ex_rs2_data <= '0;
      bus.ex_imm      <= '0;
      bus.ex_rs1      <= '0;
      bus.ex_rs2      <= '0;
      bus.ex_rd       <= '0;
    end else if (bus.flush || (!bus.ex_stall && load_use)) begin
      // Bubble: kill side effects only; ALUSrc and data fields keep their values.
      bus.ex_valid    <= 1'b0;
      bus.ex_Branch   <= 1'b0;
      bus.ex_MemREAD  <= 1'b0;
      bus.ex_MemtoReg <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_MemWrite <= WRITE_IDLE;
    end else if (!bus.ex_stall) begin
      bus.ex_valid    <= bus.id_valid;
      bus.ex_Branch   <= bus.id_valid && bus.id_Branch;
      bus.ex_MemREAD  <= bus.id_valid && bus.id_MemREAD;
      bus.ex_MemtoReg <= bus.id_valid && bus.id_MemtoReg;
      bus.ex_ALUSrc   <= bus.id_valid && bus.id_ALUSrc;
      bus.ex_RegWrite <= bus.id_valid && bus.id_RegWrite;
      bus.ex_MemWrite <= bus.id_valid ? bus.id_MemWrite : WRITE_IDLE;
      bus.ex_opcode   <= bus.id_opcode;
      bus.ex_funct3   <= bus.id_funct3;
      bus.ex_funct7   <= bus.id_funct7;
      bus.ex_pc       <= bus.id_pc;
      bus.ex_rs1_data <= bus.id_rs1_data;
      bus.ex_rs2_data <= bus.id_rs2_data;
      bus.ex_imm      <= bus.id_imm;
      bus.ex_rs1      <= bus.id_rs1;
      bus.ex_rs2      <= bus.id_rs2;
      bus.ex_rd       <= bus.id_rd;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
      perf_hold_cnt   <= '0;
    end else begin
      if (bus.flush && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (!bus.flush && bus.ex_stall && (perf_hold_cnt != 32'hFFFF_FFFF))
        perf_hold_cnt <= perf_hold_cnt + 32'd1;
      if (!bus.flush && !bus.ex_stall && load_use && (perf_bubble_cnt != 32'hFFFF_FFFF))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; perf counter checks build only with ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_OP   = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [1:0] WRITE_WORD = 2'b11;

  logic clk, rst_n;
  int   cmp_cnt = 0;
  int   mis_cnt = 0;

  id_ex_if #(.XLEN(32), .REGW(5)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt, perf_flush_cnt, perf_hold_cnt;
  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_hold_cnt(perf_hold_cnt));
`else
  id_ex_stage #(.XLEN(32), .REGW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] op, input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic br,
                        input logic mr, input logic m2r, input logic as, input logic rw,
                        input logic [1:0] mw, input logic [31:0] pc);
    bus.id_opcode   = op;
    bus.id_funct3   = pc[2:0];
    bus.id_funct7   = pc[9:3];
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_Branch   = br;
    bus.id_MemREAD  = mr;
    bus.id_MemtoReg = m2r;
    bus.id_ALUSrc   = as;
    bus.id_RegWrite = rw;
    bus.id_MemWrite = mw;
    bus.id_pc       = pc;
    bus.id_rs1_data = pc ^ 32'hA5A5_0000;
    bus.id_rs2_data = pc ^ 32'h5A5A_0000;
    bus.id_imm      = pc + 32'd4;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.ex_stall = 1'b0;
    bus.flush = 1'b0;
    set_id(OP_OP, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    #1;
    cmp_cnt++; if (bus.ex_valid !== 1'b0) begin mis_cnt++; $display("FAIL reset_ex_valid got %b exp 0", bus.ex_valid); end
    cmp_cnt++; if (bus.ex_MemWrite !== 2'b00) begin mis_cnt++; $display("FAIL reset_memwrite got %b exp 00", bus.ex_MemWrite); end
    cmp_cnt++; if (bus.id_stall !== 1'b0) begin mis_cnt++; $display("FAIL reset_id_stall got %b exp 0", bus.id_stall); end
    #1 rst_n = 1'b1;
    // EX gets a LOAD rd=5 with RegWrite, ID waits on it
    set_id(OP_LOAD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'h40);
    tick;
    set_id(OP_OP, 1'b1, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h44);
    #1;
    cmp_cnt++; if (bus.ex_RegWrite !== 1'b1) begin mis_cnt++; $display("FAIL pre_reset_regwrite got %b exp 1", bus.ex_RegWrite); end
    cmp_cnt++; if (bus.id_stall !== 1'b1) begin mis_cnt++; $display("FAIL pre_reset_stall got %b exp 1", bus.id_stall); end
    rst_n = 1'b0;
    #1;
    cmp_cnt++; if (bus.ex_valid !== 1'b0) begin mis_cnt++; $display("FAIL midreset_ex_valid got %b exp 0", bus.ex_valid); end
    cmp_cnt++; if (bus.ex_RegWrite !== 1'b0) begin mis_cnt++; $display("FAIL midreset_regwrite got %b exp 0", bus.ex_RegWrite); end
    cmp_cnt++; if (bus.ex_pc !== 32'h0) begin mis_cnt++; $display("FAIL midreset_pc got %h exp 0", bus.ex_pc); end
    cmp_cnt++; if (bus.id_stall !== 1'b0) begin mis_cnt++; $display("FAIL midreset_stall got %b exp 0", bus.id_stall); end
    #1 rst_n = 1'b1;
    tick;
    cmp_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== OP_OP || bus.ex_pc !== 32'h44) begin
      mis_cnt++; $display("FAIL post_reset_load got v=%b op=%h pc=%h exp v=1 op=33 pc=44", bus.ex_valid, bus.ex_opcode, bus.ex_pc); end
  endtask

  task automatic test_load_use;
    set_id(OP_LOAD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'h80);
    tick;
    set_id(OP_OP, 1'b1, 5'd1, 5'd5, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h84);
    #1;
    cmp_cnt++; if (bus.id_stall !== 1'b1) begin mis_cnt++; $display("FAIL lu_stall got %b exp 1", bus.id_stall); end
    tick;
    cmp_cnt++; if (bus.ex_valid !== 1'b0 || bus.ex_MemWrite !== 2'b00 || bus.ex_MemREAD !== 1'b0) begin
      mis_cnt++; $display("FAIL lu_bubble got v=%b mw=%b mr=%b exp 0 00 0", bus.ex_valid, bus.ex_MemWrite, bus.ex_MemREAD); end
    cmp_cnt++; if (bus.id_stall !== 1'b0) begin mis_cnt++; $display("FAIL lu_release got %b exp 0", bus.id_stall); end
    tick;
    cmp_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_rs2 !== 5'd5 || bus.ex_pc !== 32'h84) begin
      mis_cnt++; $display("FAIL lu_load got v=%b rs2=%0d pc=%h exp 1 5 84", bus.ex_valid, bus.ex_rs2, bus.ex_pc); end
  endtask

  task automatic test_load_use_cases;
    logic [6:0] ops [5] = '{OP_OP, OP_LUI, OP_IMM, OP_IMM, OP_ST};
    logic [4:0] rds [5] = '{5'd0, 5'd7, 5'd7, 5'd7, 5'd7};
    logic [4:0] r1s [5] = '{5'd0, 5'd7, 5'd1, 5'd7, 5'd2};
    logic [4:0] r2s [5] = '{5'd3, 5'd2, 5'd7, 5'd2, 5'd7};
    logic       exp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      set_id(OP_LOAD, 1'b1, 5'd1, 5'd0, rds[i], 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'h100 + i);
      tick;
      set_id(ops[i], 1'b1, r1s[i], r2s[i], 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h180);
      #1;
      cmp_cnt++; if (bus.id_stall !== exp[i]) begin mis_cnt++; $display("FAIL lu_case%0d got %b exp %b", i, bus.id_stall, exp[i]); end
      set_id(OP_OP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1F0);
      tick;
      tick;
    end
  endtask

  task automatic test_hold;
    set_id(OP_OP, 1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h200);
    tick;
    set_id(OP_ST, 1'b1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, WRITE_WORD, 32'h204);
    bus.ex_stall = 1'b1;
    #1;
    cmp_cnt++; if (bus.id_stall !== 1'b1) begin mis_cnt++; $display("FAIL hold_stall0 got %b exp 1", bus.id_stall); end
    for (int i = 0; i < 3; i++) begin
      tick;
      cmp_cnt++; if (bus.ex_pc !== 32'h200 || bus.ex_valid !== 1'b1 || bus.ex_MemWrite !== 2'b00 ||
                     bus.ex_RegWrite !== 1'b1 || bus.id_stall !== 1'b1) begin
        mis_cnt++; $display("FAIL hold_cycle%0d got pc=%h v=%b mw=%b rw=%b st=%b exp 200 1 00 1 1",
                            i, bus.ex_pc, bus.ex_valid, bus.ex_MemWrite, bus.ex_RegWrite, bus.id_stall); end
    end
    bus.ex_stall = 1'b0;
    tick;
    cmp_cnt++; if (bus.ex_MemWrite !== WRITE_WORD || bus.ex_pc !== 32'h204 || bus.ex_ALUSrc !== 1'b1) begin
      mis_cnt++; $display("FAIL hold_release got mw=%b pc=%h as=%b exp 11 204 1", bus.ex_MemWrite, bus.ex_pc, bus.ex_ALUSrc); end
  endtask

  task automatic test_flush;
    set_id(OP_LOAD, 1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'h300);
    tick;
    set_id(OP_OP, 1'b1, 5'd9, 5'd2, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h304);
    bus.ex_stall = 1'b1;
    bus.flush = 1'b1;
    #1;
    cmp_cnt++; if (bus.id_stall !== 1'b0) begin mis_cnt++; $display("FAIL flush_stall got %b exp 0", bus.id_stall); end
    tick;
    bus.ex_stall = 1'b0;
    bus.flush = 1'b0;
    cmp_cnt++; if (bus.ex_valid !== 1'b0 || bus.ex_Branch !== 1'b0 || bus.ex_RegWrite !== 1'b0 ||
                   bus.ex_MemREAD !== 1'b0 || bus.ex_MemtoReg !== 1'b0) begin
      mis_cnt++; $display("FAIL flush_bubble got v=%b br=%b rw=%b mr=%b m2r=%b exp all 0",
                          bus.ex_valid, bus.ex_Branch, bus.ex_RegWrite, bus.ex_MemREAD, bus.ex_MemtoReg); end
    cmp_cnt++; if (bus.ex_ALUSrc !== 1'b1 || bus.ex_pc !== 32'h300 || bus.ex_rd !== 5'd9) begin
      mis_cnt++; $display("FAIL flush_hold_data got as=%b pc=%h rd=%0d exp 1 300 9", bus.ex_ALUSrc, bus.ex_pc, bus.ex_rd); end
  endtask

  task automatic test_invalid_load;
    set_id(OP_ST, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 32'h400);
    tick;
    cmp_cnt++; if (bus.ex_valid !== 1'b0 || bus.ex_RegWrite !== 1'b0 || bus.ex_MemWrite !== 2'b00 ||
                   bus.ex_Branch !== 1'b0 || bus.ex_MemREAD !== 1'b0) begin
      mis_cnt++; $display("FAIL invalid_ctrl got v=%b rw=%b mw=%b br=%b mr=%b exp 0 0 00 0 0",
                          bus.ex_valid, bus.ex_RegWrite, bus.ex_MemWrite, bus.ex_Branch, bus.ex_MemREAD); end
    cmp_cnt++; if (bus.ex_pc !== 32'h400 || bus.ex_imm !== 32'h404) begin
      mis_cnt++; $display("FAIL invalid_data got pc=%h imm=%h exp 400 404", bus.ex_pc, bus.ex_imm); end
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_id(OP_LOAD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'h500);
      tick;
      set_id(OP_OP, 1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h504);
      tick;
      tick;
    end
    bus.ex_stall = 1'b1;
    repeat (4) tick;
    bus.ex_stall = 1'b0;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    cmp_cnt++; if (perf_bubble_cnt !== 32'd2) begin mis_cnt++; $display("FAIL perf_bubble got %0d exp 2", perf_bubble_cnt); end
    cmp_cnt++; if (perf_flush_cnt !== 32'd1) begin mis_cnt++; $display("FAIL perf_flush got %0d exp 1", perf_flush_cnt); end
    cmp_cnt++; if (perf_hold_cnt !== 32'd4) begin mis_cnt++; $display("FAIL perf_hold got %0d exp 4", perf_hold_cnt); end
    dut.perf_flush_cnt = 32'hFFFF_FFFE;
    bus.flush = 1'b1;
    repeat (3) tick;
    bus.flush = 1'b0;
    cmp_cnt++; if (perf_flush_cnt !== 32'hFFFF_FFFF) begin mis_cnt++; $display("FAIL perf_sat got %h exp ffffffff", perf_flush_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_load_use;
    test_load_use_cases;
    test_hold;
    test_flush;
    test_invalid_load;
`ifdef ID_EX_PERF_CNT_EN
    test_perf;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the ID-stage controller.
- Latches decoded control bits (Branch, MemREAD, MemtoReg, MemWrite, ALUSrc, RegWrite) and operand data from ID for use by EX.
- Owns load-use hazard detection, bubble injection, EX back-pressure hold, and flush on a taken branch or jump.
- Drives the stall request back to PC and the IF/ID register.

Parameters:
XLEN, 32, datapath width of pc/rs1_data/rs2_data/imm
REGW, 5, register index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_opcode  in  7  ID instruction opcode
id_funct3  in  3  ID funct3
id_funct7  in  7  ID funct7
id_Branch, id_MemREAD, id_MemtoReg, id_ALUSrc, id_RegWrite  in  1 each  controller outputs
id_MemWrite  in  2  controller store-size code (0 = WRITE_IDLE)
id_valid  in  1  ID holds a real instruction
id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID operands
id_rs1, id_rs2, id_rd  in  REGW each  register indices
ex_stall  in  1  EX/MEM cannot accept a new instruction
flush  in  1  taken branch/jump resolved in EX; kill ID
id_stall  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1  EX stage holds a real instruction
ex_* (Branch, MemREAD, MemtoReg, ALUSrc, RegWrite, MemWrite, opcode, funct3, funct7, pc, rs1_data, rs2_data, imm, rs1, rs2, rd)  out  matching widths  registered copies

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: all ex_* outputs are 0, so ex_MemWrite = 2'b00 (IDLE).
  - ex_valid = 0.
  - id_stall is combinational and reads 0 because ex_valid is 0.
- uses_rs1 (combinational): 1 unless id_opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
- uses_rs2 (combinational): 1 only for BRANCH (1100011), STORE (0100011) or OP (0110011).
- load_use condition: ex_valid && ex_MemREAD && ex_rd != 0 && id_valid && ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd)).
- id_stall = !flush && (ex_stall || load_use). It is purely combinational, with no cycle of latency.
- Per-edge priority, first match wins:
  1. flush: insert a bubble.
  2. ex_stall: hold every register unchanged, including ex_valid.
  3. load_use: insert a bubble.
  4. Otherwise load all id_* fields; ex_valid <= id_valid.
- Bubble definition:
  - ex_valid, ex_Branch, ex_MemREAD, ex_MemtoReg and ex_RegWrite go to 0; ex_MemWrite goes to IDLE.
  - ex_ALUSrc and all data/index fields hold their previous values.
- If id_valid = 0 on a normal load, the control bits are loaded as 0 regardless of the id_* control inputs. No side effects leak into EX.
- Load-use penalty is exactly one cycle. After the bubble, ex_MemREAD = 0, so load_use drops and the held ID instruction is loaded on the next edge.
- Simultaneous flush and ex_stall: flush wins and EX becomes a bubble. The EX owner must only assert flush when EX can advance.
- Simultaneous flush and load_use: a bubble is inserted and id_stall = 0, so IF/ID takes the redirect target.
- Reset mid-stall: all state clears immediately and id_stall releases combinationally.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds three outputs, each reset to 0:
  - perf_bubble_cnt (32): increments on every load-use bubble.
  - perf_flush_cnt (32): increments on every edge with flush = 1.
  - perf_hold_cnt (32): increments on every edge with ex_stall = 1 and flush = 0.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- When not defined, the ports and logic are absent and the core behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle while ex_valid = 1 and ex_RegWrite = 1 -> all ex_* outputs go to 0 immediately and id_stall = 0; release -> the first edge loads ID.
- Load-use:
  - Stimulus: EX holds LOAD with rd = 5, MemREAD = 1; ID holds OP with rs2 = 5.
  - Response: id_stall = 1 for one cycle; the next edge yields ex_valid = 0 and ex_MemWrite = 0; the following edge loads the OP with ex_rs2 = 5 and ex_valid = 1.
- Load-use negatives, each giving id_stall = 0:
  - EX LOAD with rd = 0, ID rs1 = 0.
  - EX LOAD with rd = 7, ID LUI with rs1 field = 7.
  - EX LOAD with rd = 7, ID OP_IMM with rs2 field = 7.
- Hold: assert ex_stall for 3 cycles with ID = STORE SW (MemWrite = WRITE_WORD) -> ex_* are unchanged for 3 edges and id_stall = 1 throughout; on release the STORE loads.
- Flush: assert flush together with ex_stall = 1 and load_use = 1 -> id_stall = 0; the next edge yields ex_valid = 0, ex_Branch = 0 and ex_RegWrite = 0.
- Counter (with ID_EX_PERF_CNT_EN): 2 load-use bubbles, 1 flush and 4 hold cycles -> perf_bubble_cnt = 2, perf_flush_cnt = 1, perf_hold_cnt = 4. Preload to FFFF_FFFE and apply 3 flushes -> perf_flush_cnt = FFFF_FFFF.
